// File: rtl/cnn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cnn_pkg: shared widths, state encoding and sizing helpers for the     |
// | 1-D convolution stage.                                   Rev 1.0      |
// +----------------------------------------------------------------------+
package cnn_pkg;

    localparam int CNN_DATA_W = 13;
    localparam int CNN_COEF_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Full-precision sum of K signed products needs log2(K) growth bits.
    function automatic int acc_width(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

    function automatic int addr_width(input int taps);
        return (taps > 1) ? $clog2(taps) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cnn_relu_sat.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cnn_relu_sat: arithmetic shift, ReLU and positive clamp of the        |
// | convolution accumulator.                                 Rev 1.0      |
// +----------------------------------------------------------------------+
module cnn_relu_sat #(
    parameter int ACC_W  = 23,
    parameter int DATA_W = 13,
    parameter int FRAC   = 0
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DATA_W-1:0] res
);

    localparam logic signed [ACC_W-1:0] MAX_POS =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};

    logic signed [ACC_W-1:0] shifted;

    assign shifted = acc >>> FRAC;

    always_comb begin
        if (shifted < 0)
            res = '0;
        else if (shifted > MAX_POS)
            res = MAX_POS[DATA_W-1:0];
        else
            res = shifted[DATA_W-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/cnn_conv1d_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cnn_conv1d_stage: streaming K-tap 1-D convolution, ReLU/saturate and  |
// | non-overlapping max-pool over one frame of N_IN samples.  Rev 1.0     |
// +----------------------------------------------------------------------+
module cnn_conv1d_stage
    import cnn_pkg::*;
#(
    parameter int DATA_W = CNN_DATA_W,
    parameter int COEF_W = CNN_COEF_W,
    parameter int K      = 3,
    parameter int N_IN   = 16,
    parameter int POOL   = 2,
    parameter int FRAC   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          w_wr,
    input  logic [addr_width(K)-1:0]      w_addr,
    input  logic signed [COEF_W-1:0]      w_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [DATA_W-1:0]      in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [DATA_W-1:0]      out_data,
    output logic                          done
);

    localparam int ACC_W = acc_width(DATA_W, COEF_W, K);
    localparam int CNT_W = $clog2(N_IN + 1);
    localparam int PW    = (POOL > 1) ? $clog2(POOL) : 1;

    state_t                   state, state_nx;
    logic signed [COEF_W-1:0] weights [K];
    logic signed [DATA_W-1:0] window  [K];
    logic signed [DATA_W-1:0] taps    [K];
    logic [CNT_W-1:0]         cnt;
    logic [PW-1:0]            pool_cnt;
    logic signed [DATA_W-1:0] pool_max, pool_cand, conv_res;
    logic signed [ACC_W-1:0]  acc;
    logic                     full;
    logic                     accept, frame_last, conv_valid, emit, out_pending_nx;

    // Once the whole frame is in, hold off the next frame until its result drains.
    assign in_ready       = (state != ST_DONE) && !full && (!out_valid || out_ready);
    assign accept         = in_valid && in_ready;
    assign frame_last     = accept && (cnt == CNT_W'(N_IN - 1));
    assign conv_valid     = accept && (cnt >= CNT_W'(K - 1));
    assign pool_cand      = (conv_res > pool_max) ? conv_res : pool_max;
    assign emit           = conv_valid && (pool_cnt == PW'(POOL - 1));
    assign out_pending_nx = emit || (out_valid && !out_ready);
    assign done           = (state == ST_DONE);

    // The convolution sees the window as it will be after this sample shifts in.
    always_comb begin
        taps[0] = in_data;
        for (int i = 1; i < K; i++)
            taps[i] = window[i-1];
    end

    always_comb begin
        acc = '0;
        for (int i = 0; i < K; i++)
            acc = acc + (ACC_W'(taps[i]) * ACC_W'(weights[i]));
    end

    cnn_relu_sat #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W),
        .FRAC   (FRAC)
    ) u_relu_sat (
        .acc (acc),
        .res (conv_res)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept) state_nx = (K == 1) ? ST_RUN : ST_FILL;
            ST_FILL: if (accept && (cnt == CNT_W'(K - 1))) state_nx = ST_RUN;
            ST_RUN:  state_nx = ST_RUN;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
        if ((state != ST_DONE) && (frame_last || full) && !out_pending_nx)
            state_nx = ST_DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            pool_cnt  <= '0;
            pool_max  <= '0;
            full      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            for (int i = 0; i < K; i++) begin
                weights[i] <= '0;
                window[i]  <= '0;
            end
        end else begin
            state <= state_nx;

            if ((state == ST_IDLE) && w_wr && (32'(w_addr) < K))
                weights[w_addr] <= w_data;

            if (accept) begin
                window[0] <= in_data;
                for (int i = 1; i < K; i++)
                    window[i] <= window[i-1];
                cnt <= cnt + CNT_W'(1);
                if (frame_last)
                    full <= 1'b1;
            end

            if (conv_valid) begin
                if (emit) begin
                    pool_cnt <= '0;
                    pool_max <= '0;
                end else begin
                    pool_cnt <= pool_cnt + PW'(1);
                    pool_max <= pool_cand;
                end
            end

            if (emit) begin
                out_valid <= 1'b1;
                out_data  <= pool_cand;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (state == ST_DONE) begin
                cnt      <= '0;
                full     <= 1'b0;
                pool_cnt <= '0;
                pool_max <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cnn_conv1d_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cnn_conv1d_stage: directed frames with a queued scoreboard and an  |
// | independent output monitor.                              Rev 1.0      |
// +----------------------------------------------------------------------+
module tb_cnn_conv1d_stage;

    logic                clk = 1'b0;
    logic                rst, w_wr, in_valid, in_ready, out_valid, out_ready, done;
    logic [1:0]          w_addr;
    logic signed [7:0]   w_data;
    logic signed [12:0]  in_data, out_data;

    int errors = 0, checks = 0, cycle = 0, last_xfer = -100, done_seen = 0, exp_v;
    int exp_q[$];
    int ramp_exp[7] = '{9, 15, 21, 27, 33, 39, 45};

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    cnn_conv1d_stage dut (
        .clk       (clk),
        .rst       (rst),
        .w_wr      (w_wr),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .done      (done)
    );

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks done timing.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("out_unexpected", int'(out_data), -1);
            end else begin
                exp_v = exp_q.pop_front();
                check("out_data", int'(out_data), exp_v);
            end
            last_xfer = cycle;
        end
        if (!rst && done) begin
            check("done_after_last_xfer", cycle - last_xfer, 1);
            check("done_queue_empty", exp_q.size(), 0);
            check("in_ready_in_done", int'(in_ready), 0);
            done_seen++;
        end
    end

    task automatic write_w(input int addr, input int d);
        w_wr   = 1'b1;
        w_addr = 2'(addr);
        w_data = 8'(d);
        @(posedge clk); #1;
        w_wr   = 1'b0;
    endtask

    task automatic set_w(input int a, input int b, input int c);
        write_w(0, a);
        write_w(1, b);
        write_w(2, c);
    endtask

    task automatic send_sample(input int v);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = 13'(v);
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!ok) check("in_ready_timeout", 0, 1);
    endtask

    // mode 0: ramp 1..16, 1: constant 4095, 2: ramp with a weight write mid-frame
    task automatic send_frame(input int mode);
        for (int n = 1; n <= 16; n++) begin
            if (mode == 2 && n == 8) begin
                w_wr   = 1'b1;
                w_addr = 2'd0;
                w_data = 8'sd100;
            end
            send_sample(mode == 1 ? 4095 : n);
            w_wr = 1'b0;
        end
    endtask

    // kind 0: ramp sums, 1: saturated, 2: all zero
    task automatic push_exp(input int kind);
        for (int i = 0; i < 7; i++)
            exp_q.push_back(kind == 0 ? ramp_exp[i] : (kind == 1 ? 4095 : 0));
    endtask

    task automatic wait_done();
        int start = done_seen;
        for (int t = 0; t < 200 && done_seen == start; t++)
            @(posedge clk);
        #1;
        if (done_seen == start) check("done_timeout", 0, 1);
    endtask

    task automatic stall_first_output();
        bit found = 1'b0;
        for (int t = 0; t < 200 && !found; t++) begin
            @(negedge clk);
            found = out_valid;
        end
        if (!found) check("stall_valid_timeout", 0, 1);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            check("stall_in_ready", int'(in_ready), 0);
            check("stall_out_data", int'(out_data), 9);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
    endtask

    task automatic check_idle_outputs(input string tag);
        @(negedge clk);
        check({tag, "_in_ready"}, int'(in_ready), 1);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_out_data"}, int'(out_data), 0);
        check({tag, "_done"}, int'(done), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; w_wr = 1'b0; w_addr = '0; w_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_idle_outputs("reset");

        // Basic ramp with unit weights.
        set_w(1, 1, 1);
        push_exp(0);
        send_frame(0);
        wait_done();

        // Negative weight: every result clipped to zero by ReLU.
        set_w(-1, 0, 0);
        push_exp(2);
        send_frame(0);
        wait_done();

        // Full-scale input and weights saturate to the positive limit.
        set_w(127, 127, 127);
        push_exp(1);
        send_frame(1);
        wait_done();

        // Back-pressure on the first output.
        set_w(1, 1, 1);
        out_ready = 1'b0;
        push_exp(0);
        fork
            send_frame(0);
            stall_first_output();
        join
        wait_done();

        // Abort a frame with reset after five samples; first pool result already left.
        exp_q.push_back(9);
        for (int n = 1; n <= 5; n++) send_sample(n);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle_outputs("midreset");
        check("midreset_queue", exp_q.size(), 0);
        set_w(1, 1, 1);
        push_exp(0);
        send_frame(0);
        wait_done();

        // Out-of-range address in IDLE and a write during the frame are both ignored.
        write_w(3, 100);
        push_exp(0);
        send_frame(2);
        wait_done();

        repeat (3) @(posedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        check("done_count", done_seen, 6);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
